// File: rtl/pixel_spi_serializer.sv
// rtl/pixel_spi_serializer.sv - pixel word FIFO feeding an MSB-first SPI mode-0 serializer
module pixel_spi_serializer #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter int CLK_DIV = 2
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         data_in,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     sclk,
    output logic                     mosi,
    output logic                     cs_n,
    output logic                     busy,
    output logic                     word_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count_next;
    logic [WIDTH-1:0]   head;
    logic [WIDTH-1:0]   shreg;
    logic [DW-1:0]      div_cnt;
    logic [BW-1:0]      bit_cnt;
    logic               pop;
    logic               push;
    logic               tick;
    logic               last_fall;

    assign head      = mem[rd_ptr];
    assign tick      = (div_cnt == DW'(CLK_DIV - 1));
    assign last_fall = (state == SHIFT) && tick && sclk && (bit_cnt == BW'(WIDTH));
    assign pop       = (state == LOAD) && !clear;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign push      = wr_en && !clear && (!full || pop);
    assign busy      = (state != IDLE);

    always_comb begin
        count_next = count;
        if (clear)
            count_next = '0;
        else if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            count <= count_next;
            full  <= (count_next == (AW + 1)'(DEPTH));
            empty <= (count_next == '0);
            if (clear) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                overflow <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (wr_en && !push)
                    overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!empty) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (last_fall) state_next = empty ? GAP : LOAD;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clear)
            state_next = IDLE;
    end

    // Serial outputs are registered from the next state so they track the FSM without glitches.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shreg     <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            cs_n      <= 1'b1;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            cs_n      <= !(state_next == LOAD || state_next == SHIFT);
            if (clear) begin
                sclk    <= 1'b0;
                mosi    <= 1'b0;
                div_cnt <= '0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    LOAD: begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end
                    SHIFT: begin
                        if (tick) begin
                            div_cnt <= '0;
                            sclk    <= !sclk;
                            if (!sclk) begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end else begin
                                shreg <= shreg << 1;
                                mosi  <= shreg[WIDTH-2];
                            end
                            if (last_fall)
                                word_done <= 1'b1;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
                // Entering LOAD presents the head word's MSB before the first rising sclk.
                if (state_next == LOAD) begin
                    shreg <= head;
                    mosi  <= head[WIDTH-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_spi_serializer.sv
// tb/tb_pixel_spi_serializer.sv - scoreboard bench for pixel_spi_serializer
module tb_pixel_spi_serializer;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        clear = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] data_in = '0;
    logic        full, empty, overflow, sclk, mosi, cs_n, busy, word_done;
    logic [3:0]  count;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_q[$];
    logic [15:0] rx_sh = '0;
    int          rx_bits = 0;
    int          rx_words = 0;
    int          rises = 0;
    int          wd_pulses = 0;
    int          cs_highs = 0;
    logic        sclk_prev = 1'b0;
    logic        cs_prev = 1'b1;
    logic [15:0] t2_words [3] = '{16'h0001, 16'hFFFF, 16'h8000};

    always #5 clk = ~clk;

    pixel_spi_serializer #(.WIDTH(16), .DEPTH(8), .CLK_DIV(2)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .clear     (clear),
        .wr_en     (wr_en),
        .data_in   (data_in),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs_n      (cs_n),
        .busy      (busy),
        .word_done (word_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sample();
        logic [15:0] e;
        if (sclk && !sclk_prev) begin
            rises++;
            rx_sh = {rx_sh[14:0], mosi};
            rx_bits++;
            if (rx_bits == 16) begin
                rx_bits = 0;
                rx_words++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_word", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("serial_word", rx_sh, e);
                end
            end
        end
        if (word_done) wd_pulses++;
        if (cs_n && !cs_prev) cs_highs++;
        sclk_prev = sclk;
        cs_prev   = cs_n;
    endtask

    task automatic step();
        @(negedge clk);
        sample();
    endtask

    task automatic flush_monitor();
        rx_bits = 0;
        exp_q.delete();
    endtask

    task automatic push_word(input logic [15:0] w);
        exp_q.push_back(w);
        data_in = w;
        wr_en   = 1'b1;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int n;
        n = 0;
        while (!(busy == 1'b0 && empty == 1'b1) && n < bound) begin
            step();
            n++;
        end
        check_eq({tag, "_idle_busy"}, busy, 0);
        check_eq({tag, "_idle_empty"}, empty, 1);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_count"}, count, 0);
        check_eq({tag, "_empty"}, empty, 1);
        check_eq({tag, "_full"}, full, 0);
        check_eq({tag, "_overflow"}, overflow, 0);
        check_eq({tag, "_sclk"}, sclk, 0);
        check_eq({tag, "_mosi"}, mosi, 0);
        check_eq({tag, "_cs_n"}, cs_n, 1);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_word_done"}, word_done, 0);
    endtask

    initial begin
        int k, n, first_rise, done_k, saved, exp_cnt;

        repeat (3) step();
        check_reset("reset");
        nrst = 1'b1;
        step();

        // single word: latency, bit order, SHIFT length, GAP
        push_word(16'hA5C3);
        check_eq("t1_empty_after_push", empty, 0);
        check_eq("t1_count_after_push", count, 1);
        check_eq("t1_cs_idle", cs_n, 1);
        step();
        check_eq("t1_cs_low_load", cs_n, 0);
        check_eq("t1_busy_load", busy, 1);
        step();
        check_eq("t1_popped", count, 0);
        k = 0; first_rise = -1; done_k = -1; wd_pulses = 0;
        while (done_k < 0 && k < 300) begin
            if (sclk && first_rise < 0) first_rise = k;
            if (word_done) done_k = k;
            else begin
                step();
                k++;
            end
        end
        check_eq("t1_first_rise", first_rise, 2);
        check_eq("t1_shift_len", done_k, 64);
        check_eq("t1_gap_cs", cs_n, 1);
        check_eq("t1_gap_busy", busy, 1);
        step();
        check_eq("t1_done_width", word_done, 0);
        check_eq("t1_idle_busy", busy, 0);
        check_eq("t1_idle_empty", empty, 1);
        check_eq("t1_wd_pulses", wd_pulses, 1);
        check_eq("t1_rx_words", rx_words, 1);

        // back-to-back words with no GAP
        rises = 0; wd_pulses = 0; cs_highs = 0; rx_words = 0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(t2_words[i]);
            data_in = t2_words[i];
            wr_en   = 1'b1;
            step();
        end
        wr_en = 1'b0;
        wait_idle(400, "t2");
        check_eq("t2_rises", rises, 48);
        check_eq("t2_wd_pulses", wd_pulses, 3);
        check_eq("t2_cs_highs", cs_highs, 1);
        check_eq("t2_rx_words", rx_words, 3);
        check_eq("t2_queue_left", exp_q.size(), 0);

        // ten consecutive writes: occupancy, full, dropped word, sticky overflow
        rx_words = 0;
        for (int i = 0; i < 10; i++) begin
            data_in = 16'(i);
            wr_en   = 1'b1;
            if (i < 9) exp_q.push_back(16'(i));
            step();
            exp_cnt = (i < 2) ? i + 1 : ((i <= 8) ? i : 8);
            check_eq($sformatf("t3_count_w%0d", i), count, exp_cnt);
            if (i == 7) check_eq("t3_not_full_w7", full, 0);
            if (i == 8) check_eq("t3_full_w8", full, 1);
            if (i == 8) check_eq("t3_no_ovf_w8", overflow, 0);
            if (i == 9) check_eq("t3_ovf_w9", overflow, 1);
        end
        wr_en = 1'b0;
        wait_idle(1500, "t3");
        check_eq("t3_ovf_sticky", overflow, 1);
        check_eq("t3_rx_words", rx_words, 9);
        check_eq("t3_queue_left", exp_q.size(), 0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_eq("t3_ovf_cleared", overflow, 0);

        // push while full during the LOAD pop cycle
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(16'h4000 + 16'(i));
            data_in = 16'h4000 + 16'(i);
            wr_en   = 1'b1;
            step();
        end
        wr_en = 1'b0;
        check_eq("t4_full", full, 1);
        n = 0;
        while (!word_done && n < 200) begin
            step();
            n++;
        end
        check_eq("t4_load_count", count, 8);
        check_eq("t4_load_busy", busy, 1);
        push_word(16'h40AA);
        check_eq("t4_count_held", count, 8);
        check_eq("t4_full_held", full, 1);
        check_eq("t4_no_ovf", overflow, 0);
        wait_idle(1500, "t4");
        check_eq("t4_queue_left", exp_q.size(), 0);

        // clear in the middle of a word with three words queued
        for (int i = 0; i < 4; i++) push_word(16'hC001 + 16'(i));
        check_eq("t5_queued", count, 3);
        n = 0;
        while (rx_bits != 7 && n < 300) begin
            step();
            n++;
        end
        check_eq("t5_reached_bit7", rx_bits, 7);
        saved = wd_pulses;
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_eq("t5_cs_n", cs_n, 1);
        check_eq("t5_sclk", sclk, 0);
        check_eq("t5_mosi", mosi, 0);
        check_eq("t5_empty", empty, 1);
        check_eq("t5_count", count, 0);
        check_eq("t5_busy", busy, 0);
        check_eq("t5_word_done", word_done, 0);
        flush_monitor();
        repeat (10) step();
        check_eq("t5_no_done_pulse", wd_pulses, saved);
        saved = rx_words;
        push_word(16'h5A0F);
        wait_idle(300, "t5");
        check_eq("t5_rx_after_clear", rx_words, saved + 1);
        check_eq("t5_queue_left", exp_q.size(), 0);

        // asynchronous reset mid-SHIFT
        push_word(16'h1234);
        n = 0;
        while (!(rx_bits == 5 && sclk) && n < 300) begin
            step();
            n++;
        end
        check_eq("t6_reached_bit5", rx_bits, 5);
        #2 nrst = 1'b0;
        #1 check_reset("t6_async");
        flush_monitor();
        step();
        step();
        nrst = 1'b1;
        saved = rises;
        repeat (40) step();
        check_eq("t6_no_stale_bits", rises, saved);
        check_eq("t6_cs_idle", cs_n, 1);
        check_eq("t6_empty", empty, 1);
        saved = rx_words;
        push_word(16'hBEEF);
        wait_idle(300, "t6");
        check_eq("t6_rx_after_reset", rx_words, saved + 1);
        check_eq("t6_queue_left", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pixel_spi_serializer.md
Name: pixel_spi_serializer

Overview:
Downstream stage of the image controller. It buffers 16-bit pixel words taken from the controller's data_out in a small FIFO. It shifts each word out MSB-first on an SPI-style serial link (sclk/mosi/cs_n) to the display driver. Word boundaries are reported back as a one-cycle strobe, and FIFO status is exported for flow control.

Parameters:
WIDTH, 16, bits per pixel word
DEPTH, 8, FIFO entries (power of two, >= 2)
CLK_DIV, 2, system clock cycles per sclk half-period (>= 1)

Ports:
clk  input  1  system clock; all state on rising edge
nrst  input  1  asynchronous active-low reset
clear  input  1  synchronous flush/abort, priority over wr_en
wr_en  input  1  push data_in this cycle
data_in  input  WIDTH  pixel word from image controller
full  output  1  FIFO holds DEPTH words
empty  output  1  FIFO holds 0 words
count  output  $clog2(DEPTH)+1  FIFO occupancy
overflow  output  1  sticky: a push was dropped
sclk  output  1  serial clock, idle low
mosi  output  1  serial data, MSB first
cs_n  output  1  frame select, active low
busy  output  1  FSM not in IDLE
word_done  output  1  one-cycle pulse at end of each word

Behaviour:
- Clock and reset: one clock (clk); reset nrst is asynchronous, active-low.
- Reset values (immediate on nrst low, including mid-transfer): count=0, empty=1, full=0, overflow=0, sclk=0, mosi=0, cs_n=1, busy=0, word_done=0, FSM=IDLE, FIFO pointers=0.
- FIFO flags: full/empty/count are registered and derived from occupancy.
  - Push accepted when wr_en && (!full || pop this cycle).
  - A push while full with no pop is dropped and sets overflow; overflow clears only on reset or clear.
  - Simultaneous push and pop: count unchanged.
- clear: next edge empties FIFO, clears overflow, forces FSM to IDLE with cs_n=1, sclk=0, mosi=0; no word_done pulse. wr_en in the same cycle is ignored.
- FSM states IDLE, LOAD, SHIFT, GAP:
  - IDLE: cs_n=1, sclk=0. If !empty, go to LOAD.
  - LOAD (1 cycle): pop FIFO head into shift register; cs_n=0; mosi=head[WIDTH-1]; div_cnt=0, bit_cnt=0; go to SHIFT.
  - SHIFT: div_cnt counts 0..CLK_DIV-1.
    - At terminal count, sclk toggles and div_cnt wraps.
    - On each sclk 0->1 toggle, bit_cnt increments.
    - On each sclk 1->0 toggle, the shift register shifts left and mosi takes the new MSB.
    - Data changes on the falling edge and is stable across the rising edge (SPI mode 0).
    - After the WIDTH-th falling edge (SHIFT lasted 2*WIDTH*CLK_DIV cycles), word_done pulses 1 cycle. Go to LOAD if !empty (cs_n held low, back-to-back), else go to GAP.
  - GAP (1 cycle): cs_n=1, sclk=0; go to IDLE.
- Latency: push at edge N gives empty=0 after N; LOAD in cycle N+2; cs_n low from N+2; first sclk rise CLK_DIV cycles after SHIFT entry.
- sclk, mosi and cs_n are driven from registers (glitch-free).
- busy=1 in LOAD, SHIFT and GAP.

Test Plan:
1. Reset, CLK_DIV=2, push 16'hA5C3 once -> cs_n falls 2 cycles after push; mosi sampled on 16 sclk rises = 1010_0101_1100_0011; SHIFT lasts 64 cycles; one word_done pulse; cs_n high 1 cycle (GAP) then IDLE; empty=1, busy=0.
2. Push 16'h0001, 16'hFFFF, 16'h8000 on consecutive cycles -> cs_n stays low across all three words (48 rising sclk edges, 3 word_done pulses, no GAP between words); serial stream matches the words in push order.
3. wr_en high for 10 consecutive cycles from idle (data 0..9) -> pop of word 0 coincides with write 2; full asserts after write 8; write 9 dropped; overflow=1; serial output 0..8 in order; overflow stays 1 until clear.
4. Fill to full, then hold wr_en high during the LOAD pop cycle -> push accepted, count stays DEPTH, overflow unchanged.
5. clear asserted mid-word (bit 7) with 3 words queued -> next cycle: cs_n=1, sclk=0, empty=1, count=0, no word_done; a subsequent push transmits normally.
6. nrst pulsed low mid-SHIFT (between edges) -> all outputs take reset values immediately without waiting for clk; after release, the FIFO is empty and no stale bits are sent.
